// File: rtl/oam_sprite_scanner_pkg.sv
// oam_sprite_scanner_pkg: constants, scan states and line-buffer entry types for the mode-2 OAM scanner
package oam_sprite_scanner_pkg;
  localparam int OAM_ENTRIES = 40;
  localparam int MAX_LINE_SPRITES = 10;
  localparam int SPRITE_Y_OFFSET = 16;
  typedef enum logic [3:0] {IDLE, RD_Y, EV_Y, RD_X, CAP_X, RD_T, CAP_T, RD_F, CAP_F, FIN} oam_scan_state_t;
  typedef struct packed {
    logic bg_priority;
    logic y_flip;
    logic x_flip;
    logic palette;
    logic [3:0] cgb;
  } SpriteAttributeFlags;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] tile;
    SpriteAttributeFlags flags;
    logic [3:0] row;
    logic [5:0] oam_index;
  } sprite_line_entry_t;
endpackage

// File: rtl/oam_sprite_scanner_if.sv
// oam_sprite_scanner_if: OAM byte read port; rd/addr from the scanner, rdata valid the cycle after rd
interface oam_sprite_scanner_if;
  logic rd;
  logic [7:0] addr;
  logic [7:0] rdata;
  modport master (output rd, addr, input rdata);
  modport slave (input rd, addr, output rdata);
endinterface

// File: rtl/oam_sprite_scanner_line_buffer.sv
// oam_sprite_scanner_line_buffer: 10-entry selected-sprite register file, one write port, combinational read
// ports: clk, reset_n (sync, active-low), we_i/widx_i/wdata_i write, ridx_i -> rdata_o (0 when out of range)
module oam_sprite_scanner_line_buffer import oam_sprite_scanner_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic we_i,
  input  logic [3:0] widx_i,
  input  sprite_line_entry_t wdata_i,
  input  logic [3:0] ridx_i,
  output sprite_line_entry_t rdata_o
);
  sprite_line_entry_t mem_q [MAX_LINE_SPRITES];
  always_ff @(posedge clk)
    if (!reset_n) for (int k = 0; k < MAX_LINE_SPRITES; k++) mem_q[k] <= '0;
    else if (we_i && widx_i < 4'(MAX_LINE_SPRITES)) mem_q[widx_i] <= wdata_i;
  assign rdata_o = ridx_i < 4'(MAX_LINE_SPRITES) ? mem_q[ridx_i] : '0;
endmodule

// File: rtl/oam_sprite_scanner.sv
// oam_sprite_scanner: mode-2 OAM walk selecting up to 10 sprites on line LY into a line buffer
// ports: clk, reset_n (sync, active-low); start_i/ly_i/sprite_size_i control; oam OAM read port;
// busy_o/done_o/sprite_count_o status; buf_idx_i -> buf_valid_o and buf_* line-buffer read
module oam_sprite_scanner import oam_sprite_scanner_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic [7:0] ly_i,
  input  logic sprite_size_i,
  oam_sprite_scanner_if.master oam,
  output logic busy_o,
  output logic done_o,
  output logic [3:0] sprite_count_o,
  input  logic [3:0] buf_idx_i,
  output logic buf_valid_o,
  output logic [7:0] buf_x_o,
  output logic [7:0] buf_tile_o,
  output logic [7:0] buf_flags_o,
  output logic [3:0] buf_row_o,
  output logic [5:0] buf_oam_index_o
);
  oam_scan_state_t state_q, state_d;
  logic [5:0] i_q, i_d;
  logic [3:0] cnt_q, cnt_d, dy_q, dy_d;
  logic [7:0] ly_q, ly_d, x_q, x_d, tile_q, tile_d;
  logic size_q, size_d, hit, last, full, we;
  logic [4:0] h;
  logic [8:0] diff;
  SpriteAttributeFlags flg;
  sprite_line_entry_t we_entry, rd_entry;
  assign h = size_q ? 5'd16 : 5'd8;
  // a negative diff (bit 8) means the sprite starts below this line
  assign diff = {1'b0, ly_q} + 9'(SPRITE_Y_OFFSET) - {1'b0, oam.rdata};
  assign hit = !diff[8] && diff < {4'd0, h};
  assign last = i_q == 6'(OAM_ENTRIES - 1);
  // evaluated in CAP_F, before the increment lands
  assign full = cnt_q == 4'(MAX_LINE_SPRITES - 1);
  assign flg = SpriteAttributeFlags'(oam.rdata);
  assign we_entry = '{x: x_q, tile: tile_q, flags: flg,
                      row: flg.y_flip ? 4'(h - 5'd1 - {1'b0, dy_q}) : dy_q, oam_index: i_q};
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      i_q <= '0;
      cnt_q <= '0;
      dy_q <= '0;
      ly_q <= '0;
      x_q <= '0;
      tile_q <= '0;
      size_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      cnt_q <= cnt_d;
      dy_q <= dy_d;
      ly_q <= ly_d;
      x_q <= x_d;
      tile_q <= tile_d;
      size_q <= size_d;
    end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    cnt_d = cnt_q;
    dy_d = dy_q;
    ly_d = ly_q;
    x_d = x_q;
    tile_d = tile_q;
    size_d = size_q;
    case (state_q)
      IDLE: state_d = IDLE;
      RD_Y: state_d = EV_Y;
      EV_Y: begin
        dy_d = diff[3:0];
        state_d = hit ? RD_X : last ? FIN : RD_Y;
        i_d = hit || last ? i_q : i_q + 6'd1;
      end
      RD_X: state_d = CAP_X;
      CAP_X: begin
        x_d = oam.rdata;
        state_d = RD_T;
      end
      RD_T: state_d = CAP_T;
      CAP_T: begin
        tile_d = size_q ? oam.rdata & 8'hFE : oam.rdata;
        state_d = RD_F;
      end
      RD_F: state_d = CAP_F;
      CAP_F: begin
        cnt_d = cnt_q + 4'd1;
        state_d = full || last ? FIN : RD_Y;
        i_d = full || last ? i_q : i_q + 6'd1;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // start from any state restarts the walk; an in-flight read is simply ignored
    if (start_i) begin
      state_d = RD_Y;
      i_d = '0;
      cnt_d = '0;
      ly_d = ly_i;
      size_d = sprite_size_i;
    end
  end
  always_comb begin
    oam.rd = state_q inside {RD_Y, RD_X, RD_T, RD_F};
    oam.addr = oam.rd ? {i_q, state_q == RD_Y ? 2'd0 : state_q == RD_X ? 2'd1 : state_q == RD_T ? 2'd2 : 2'd3} : 8'd0;
    busy_o = !(state_q inside {IDLE, FIN});
    done_o = state_q == FIN;
    we = state_q == CAP_F;
  end
  oam_sprite_scanner_line_buffer u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .we_i(we),
    .widx_i(cnt_q),
    .wdata_i(we_entry),
    .ridx_i(buf_idx_i),
    .rdata_o(rd_entry)
  );
  assign sprite_count_o = cnt_q;
  assign buf_valid_o = buf_idx_i < cnt_q;
  assign buf_x_o = rd_entry.x;
  assign buf_tile_o = rd_entry.tile;
  assign buf_flags_o = rd_entry.flags;
  assign buf_row_o = rd_entry.row;
  assign buf_oam_index_o = rd_entry.oam_index;
endmodule

// File: tb/tb_oam_sprite_scanner.sv
// tb_oam_sprite_scanner: scoreboard bench with a line-intersection reference model
`timescale 1ns/100ps
module tb_oam_sprite_scanner;
  logic clk = 0, reset_n = 0, start_i = 0, sprite_size_i = 0;
  logic [7:0] ly_i = 0;
  logic [3:0] buf_idx_i = 0;
  logic busy_o, done_o, buf_valid_o;
  logic [3:0] sprite_count_o, buf_row_o;
  logic [7:0] buf_x_o, buf_tile_o, buf_flags_o;
  logic [5:0] buf_oam_index_o;
  oam_sprite_scanner_if oif();
  oam_sprite_scanner dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .ly_i(ly_i), .sprite_size_i(sprite_size_i),
    .oam(oif), .busy_o(busy_o), .done_o(done_o), .sprite_count_o(sprite_count_o),
    .buf_idx_i(buf_idx_i), .buf_valid_o(buf_valid_o), .buf_x_o(buf_x_o), .buf_tile_o(buf_tile_o),
    .buf_flags_o(buf_flags_o), .buf_row_o(buf_row_o), .buf_oam_index_o(buf_oam_index_o)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  always @(posedge clk) if (oif.rd) oif.rdata <= mem[oif.addr];
  int checks = 0, failures = 0, scans = 0;
  int cyc = 0, yr = 0, xr = 0;
  always @(posedge clk)
    if (start_i) begin
      cyc <= 0;
      yr <= 0;
      xr <= 0;
    end else begin
      cyc <= cyc + 1;
      yr <= yr + int'(oif.rd && oif.addr[1:0] == 2'd0);
      xr <= xr + int'(oif.rd && oif.addr[1:0] == 2'd1);
    end
  typedef struct {int count; int lat; int yr; int xr;} exp_t;
  typedef struct packed {logic [7:0] x; logic [7:0] t; logic [7:0] f; logic [3:0] r; logic [5:0] idx;} slot_t;
  exp_t exp_q[$];
  slot_t slot_q[$];
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  // sprite covers lines [Y-16, Y-16+H); first 10 in OAM order are kept
  task automatic expect_scan(input int ly, input bit sz);
    exp_t e;
    int h;
    h = sz ? 16 : 8;
    e = '{0, 0, 0, 0};
    for (int n = 0; n < 40; n++) begin
      int top;
      int r;
      top = int'(mem[4*n]) - 16;
      e.yr++;
      if (ly >= top && ly < top + h) begin
        r = ly - top;
        if (mem[4*n+3][6]) r = h - 1 - r;
        slot_q.push_back('{mem[4*n+1], sz ? mem[4*n+2] & 8'hFE : mem[4*n+2], mem[4*n+3], 4'(r), 6'(n)});
        e.count++;
        e.xr++;
        e.lat += 8;
        if (e.count == 10) break;
      end else e.lat += 2;
    end
    exp_q.push_back(e);
  endtask
  task automatic clear_oam();
    for (int a = 0; a < 256; a++) mem[a] = 0;
  endtask
  task automatic random_oam(input int ly);
    for (int n = 0; n < 40; n++) begin
      mem[4*n] = $urandom_range(0, 1) ? 8'(ly + 16 - int'($urandom_range(0, 18))) : 8'($urandom_range(0, 255));
      mem[4*n+1] = 8'($urandom);
      mem[4*n+2] = 8'($urandom);
      mem[4*n+3] = 8'($urandom);
    end
  endtask
  task automatic pulse_start(input logic [7:0] ly, input bit sz);
    @(negedge clk);
    start_i = 1;
    ly_i = ly;
    sprite_size_i = sz;
    @(negedge clk);
    start_i = 0;
  endtask
  task automatic run_scan(input logic [7:0] ly, input bit sz);
    int target;
    int t;
    target = scans + 1;
    t = 0;
    expect_scan(int'(ly), sz);
    pulse_start(ly, sz);
    while (scans < target && t < 400) begin
      @(negedge clk);
      ly_i = 8'($urandom);
      sprite_size_i = 1'($urandom);
      t++;
    end
    if (scans < target) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout waited=%0d cycles required=done", t);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (done_o) begin
      exp_t e;
      slot_t s;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("count", int'(sprite_count_o), e.count);
        chk("latency", cyc, e.lat);
        chk("y_reads", yr, e.yr);
        chk("x_reads", xr, e.xr);
        chk("busy_at_done", int'(busy_o), 0);
        for (int k = 0; k < e.count; k++) begin
          s = slot_q.pop_front();
          buf_idx_i = 4'(k);
          #0.2;
          chk("valid", int'(buf_valid_o), 1);
          chk("x", int'(buf_x_o), int'(s.x));
          chk("tile", int'(buf_tile_o), int'(s.t));
          chk("flags", int'(buf_flags_o), int'(s.f));
          chk("row", int'(buf_row_o), int'(s.r));
          chk("oam_index", int'(buf_oam_index_o), int'(s.idx));
        end
        if (e.count < 10) begin
          buf_idx_i = 4'(e.count);
          #0.2;
          chk("valid_above_count", int'(buf_valid_o), 0);
        end
        buf_idx_i = 4'($urandom_range(10, 15));
        #0.2;
        chk("oor_valid", int'(buf_valid_o), 0);
        chk("oor_x", int'(buf_x_o), 0);
        chk("oor_flags", int'(buf_flags_o), 0);
        buf_idx_i = 0;
        @(negedge clk);
        chk("done_pulse", int'(done_o), 0);
        scans++;
      end
    end
  end
  initial begin
    int ly;
    clear_oam();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_rd", int'(oif.rd), 0);
    chk("rst_addr", int'(oif.addr), 0);
    chk("rst_count", int'(sprite_count_o), 0);
    chk("rst_valid", int'(buf_valid_o), 0);
    chk("rst_x", int'(buf_x_o), 0);
    reset_n = 1;
    run_scan(0, 0);
    mem[20] = 20; mem[21] = 30; mem[22] = 8'h41; mem[23] = 8'h00;
    run_scan(6, 0);
    mem[23] = 8'h40;
    run_scan(6, 1);
    clear_oam();
    for (int n = 0; n < 12; n++) begin
      mem[4*n] = 16; mem[4*n+1] = 8'(n * 7); mem[4*n+2] = 8'(n); mem[4*n+3] = 8'(n * 16);
    end
    run_scan(0, 0);
    clear_oam();
    mem[0] = 9; mem[1] = 5; mem[4] = 8; mem[8] = 0; mem[12] = 9; mem[13] = 170; mem[15] = 8'h40;
    run_scan(0, 0);
    clear_oam();
    mem[40] = 159; mem[41] = 0; mem[42] = 3; mem[44] = 159; mem[45] = 200;
    run_scan(143, 0);
    random_oam(50);
    pulse_start(50, 1);
    repeat (30) @(negedge clk);
    random_oam(100);
    run_scan(100, 0);
    clear_oam();
    mem[0] = 16; mem[1] = 8'hAA; mem[2] = 8'h55;
    run_scan(0, 0);
    random_oam(20);
    pulse_start(20, 0);
    repeat (20) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_count", int'(sprite_count_o), 0);
    chk("midrst_rd", int'(oif.rd), 0);
    chk("midrst_done", int'(done_o), 0);
    chk("midrst_buf_x", int'(buf_x_o), 0);
    reset_n = 1;
    repeat (20) begin
      ly = int'($urandom_range(0, 143));
      random_oam(ly);
      run_scan(8'(ly), 1'($urandom));
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oam_sprite_scanner.md
Name: oam_sprite_scanner

Overview:
- Mode-2 OAM reader for the PPU: walks the 40-entry sprite attribute table, byte-serially, through a registered OAM read port.
- Selects up to 10 sprites that intersect the current line LY.
- Captures each selected sprite's X, tile, flags and in-sprite row into a line buffer.
- The downstream sprite fetcher reads that buffer during mode 3.

Parameters:
- OAM_ENTRIES, 40, number of sprite attribute entries scanned (4 bytes each).
- MAX_SPRITES, 10, maximum sprites captured per line.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse at mode-2 entry; samples ly and sprite_size.
- ly  in  8  current line (LcdY).
- sprite_size  in  1  LCDC.SpriteSize; 0 = 8x8, 1 = 8x16.
- oam_rd  out  1  OAM read strobe.
- oam_addr  out  8  OAM byte address (4*entry + byte).
- oam_rdata  in  8  OAM data; valid the cycle after oam_rd.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- sprite_count  out  4  sprites captured (0..10).
- buf_idx  in  4  line-buffer read index.
- buf_valid  out  1  buf_idx < sprite_count.
- buf_x  out  8  sprite X byte.
- buf_tile  out  8  tile number (bit0 forced 0 in 8x16 mode).
- buf_flags  out  8  attribute flags byte, unmodified.
- buf_row  out  4  row within sprite, Y-flip applied.
- buf_oam_index  out  6  source OAM entry number.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state IDLE, oam_rd=0, oam_addr=0, busy=0, done=0, sprite_count=0, entry counter=0, all line-buffer fields 0.
- Read ports: all buf_* outputs are combinational reads of the buffer registers. An out-of-range buf_idx (>=10) returns 0 with buf_valid=0.
- States: IDLE, RD_Y, EV_Y, RD_X, CAP_X, RD_T, CAP_T, RD_F, CAP_F, FIN.
- IDLE -> RD_Y on start:
  - ly and sprite_size are latched.
  - Entry counter and sprite_count are cleared.
  - Buffer contents are not cleared.
- RD_Y: oam_rd=1, oam_addr=4*i. Next state EV_Y.
- EV_Y: compute diff = {0,ly} + 16 - {0,Y} in 9 bits.
  - hit = !diff[8] && diff < H, where H = 8 or 16.
  - On hit: latch row and go to RD_X.
  - On miss: go to RD_Y for i+1, or FIN if i = OAM_ENTRIES-1.
- RD_X/CAP_X, RD_T/CAP_T, RD_F/CAP_F: each byte takes 2 cycles, read then capture, at addr 4i+1, 4i+2, 4i+3.
- CAP_F writes buffer slot sprite_count:
  - x, tile (with tile & 8'hFE when H=16), flags, row, oam_index=i.
  - sprite_count increments.
  - Next state is FIN if sprite_count reaches MAX_SPRITES or i is the last entry; otherwise RD_Y for i+1.
- Row: buf_row = flags[6] ? H-1-diff[3:0] : diff[3:0]. DMG flag bit numbering: bit7 priority, bit6 Y flip, bit5 X flip, bit4 palette.
- FIN: done=1 for one cycle, busy drops the same cycle, then IDLE. busy is 1 in every state except IDLE and FIN.
- Timing:
  - A miss costs 2 cycles; a hit costs 8 cycles.
  - All misses: done in the cycle after 80 scan cycles.
  - Worst case (10 hits): 140 scan cycles.
  - Early termination at 10 sprites; later entries are not read.
- Screen-edge sprites:
  - Y=0 and Y>=160 never hit.
  - X=0 and X>=168 sprites that hit still count toward the 10.
  - Ties keep OAM order: a lower index goes in a lower slot.
- start while busy: restart from entry 0 with sprite_count=0; the in-flight read is discarded. No done pulse is issued for the aborted scan.
- reset_n low mid-scan: IDLE on the next edge, all outputs at reset values.
- ly and sprite_size changes during a scan are ignored; the latched copies are used.

Decomposition:
- video_types package additions:
  - constants OAM_ENTRIES=40, MAX_LINE_SPRITES=10, SPRITE_Y_OFFSET=16.
  - enum oam_scan_state_t.
  - packed struct sprite_line_entry_t {x, tile, flags, row[3:0], oam_index[5:0]}.
  - Reuse SpriteAttributeFlags for the flags byte.
- Sub-module sprite_line_buffer: 10 x sprite_line_entry_t register file with one write port and one combinational read port, reset-cleared.

Test Plan:
- OAM all zero, ly=0, 8x8, start -> done exactly 81 cycles after start, sprite_count=0, 40 Y reads and no X reads.
- Entry 5 = {Y=20, X=30, T=0x41, F=0x00}, ly=6 -> count=1, slot0 = x=30, tile=0x41, row=2, oam_index=5.
- Same entry with F=0x40, sprite_size=1, ly=6 -> tile=0x40, row=13.
- Entries 0..11 all Y=16, ly=0 -> count=10, oam_index 0..9, entries 10/11 never addressed, done after 80 scan cycles.
- Boundary hits, ly=0, 8x8:
  - Y=9 -> hit, row 7.
  - Y=8 -> miss.
  - Y=0 -> miss.
  - ly=143 with Y=159 -> hit, row 0.
- Restart and reset:
  - Second start at cycle 30 of a scan -> no done at the old completion time; fresh result from entry 0.
  - reset_n=0 mid-scan -> busy=0, count=0, oam_rd=0 next cycle.
